// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/response handshake, store lane shifting, load extraction.
// Optional request timeout is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state, state_next;
    logic        mem_op, illegal, tmo_hit;
    logic [3:0]  mask_next;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        is_load_q;
    logic [31:0] load_q;
    logic        misaligned_q, timeout_q;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext;

    assign mem_op = in_valid & (in_mem_read | in_mem_write);

    always_comb begin
        illegal = 1'b0;
        if (in_mem_read && in_mem_write)
            illegal = 1'b1;
        else if (in_mem_write)
            illegal = (in_funct3 != 3'b000) && (in_funct3 != 3'b001) && (in_funct3 != 3'b010);
        else
            illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
        if (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00)
            illegal = 1'b1;
        if (in_funct3[1:0] == 2'b01 && in_addr[0])
            illegal = 1'b1;
    end

    always_comb begin
        mask_next = 4'b1111;
        if (in_mem_write) begin
            case (in_funct3[1:0])
                2'b00:   mask_next = 4'b0001 << in_addr[1:0];
                2'b01:   mask_next = 4'b0011 << {in_addr[1], 1'b0};
                default: mask_next = 4'b1111;
            endcase
        end
    end

    always_comb begin
        rbyte = 8'(dmem_rdata >> {off_q, 3'b000});
        rhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ext = {{24{rbyte[7]}}, rbyte};
            3'b100:  ext = {24'b0, rbyte};
            3'b001:  ext = {{16{rhalf[15]}}, rhalf};
            3'b101:  ext = {16'b0, rhalf};
            default: ext = dmem_rdata;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // Hit on the last permitted BUSY cycle so the request stays up exactly TIMEOUT_CYCLES cycles.
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) && !dmem_resp;

    always_ff @(posedge clk) begin
        if (rst || state != BUSY)
            tmo_cnt <= '0;
        else if (!dmem_resp)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall      = 1'b1;
                    state_next = illegal ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_resp || tmo_hit)
                    state_next = DONE;
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_address <= '0;
            dmem_wdata   <= '0;
            dmem_mbe     <= '0;
            f3_q         <= '0;
            off_q        <= '0;
            is_load_q    <= 1'b0;
            load_q       <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        f3_q         <= in_funct3;
                        off_q        <= in_addr[1:0];
                        is_load_q    <= in_mem_read & ~in_mem_write;
                        misaligned_q <= illegal;
                        timeout_q    <= 1'b0;
                        load_q       <= '0;
                        if (!illegal) begin
                            dmem_read    <= in_mem_read;
                            dmem_write   <= in_mem_write;
                            dmem_address <= {in_addr[31:2], 2'b00};
                            dmem_wdata   <= in_mem_write ? (in_wdata << {in_addr[1:0], 3'b000}) : '0;
                            dmem_mbe     <= mask_next;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_resp || tmo_hit) begin
                        dmem_read    <= 1'b0;
                        dmem_write   <= 1'b0;
                        dmem_address <= '0;
                        dmem_wdata   <= '0;
                        dmem_mbe     <= '0;
                        timeout_q    <= ~dmem_resp;
                        load_q       <= (dmem_resp && is_load_q) ? ext : '0;
                    end
                end
                default: begin
                    load_q       <= '0;
                    misaligned_q <= 1'b0;
                    timeout_q    <= 1'b0;
                end
            endcase
        end
    end

    assign load_data  = load_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the decoded control word: takes valid/mem_read/mem_write/funct3 plus the ALU-computed address and the rs2 store data.
- Drives the data-memory request/response handshake, generates the byte-enable mask and shifted write data, and extracts/extends load data.
- Holds the pipeline via stall while a request is outstanding; sits between the EX/MEM pipeline register and the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 256, cycles with dmem_request high and no dmem_resp before abort (used only with MEM_ACCESS_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  ctrl.valid of the instruction in MEM
in_mem_read  input  1  ctrl.mem_read
in_mem_write  input  1  ctrl.mem_write
in_funct3  input  3  ctrl.funct3 (load/store width)
in_addr  input  32  alu_out effective address
in_wdata  input  32  rs2_out store data
dmem_read  output  1  read request
dmem_write  output  1  write request
dmem_address  output  32  word-aligned address {in_addr[31:2],2'b00}
dmem_wdata  output  32  store data shifted into lane
dmem_mbe  output  4  byte enables
dmem_resp  input  1  memory done, one-cycle pulse
dmem_rdata  input  32  read word, valid with dmem_resp
stall  output  1  hold upstream stages
out_valid  output  1  one-cycle pulse: access finished
load_data  output  32  extended load result (0 for stores)
misaligned  output  1  qualifies out_valid: illegal/misaligned access, no memory issued
timeout  output  1  qualifies out_valid: request aborted (0 without macro)

Behaviour:
- Reset: state IDLE; dmem_read=dmem_write=0; dmem_mbe=0; dmem_address=dmem_wdata=0; out_valid=misaligned=timeout=0; load_data=0; stall=0.
- mem_op = in_valid & (in_mem_read | in_mem_write). Upstream holds all in_* stable while stall=1.
- States: IDLE, BUSY, DONE.
- IDLE, mem_op, legal: register request, go to BUSY. Request appears on dmem_* the next cycle. stall=1 combinationally in this cycle.
- IDLE, mem_op, illegal: no request, go to DONE with misaligned=1. stall=1 this cycle.
- IDLE, no mem_op: stall=0, outputs idle.
- Illegal cases:
  - lw/sw with addr[1:0]!=0.
  - lh/lhu/sh with addr[0]=1.
  - store funct3 not in {000,001,010}; load funct3 in {011,110,111}.
  - mem_read & mem_write both set.
- BUSY: dmem_read or dmem_write held constant with address/wdata/mbe until dmem_resp. On dmem_resp, capture dmem_rdata, drop request, go to DONE. stall=1.
- DONE: out_valid=1 for exactly one cycle with load_data/misaligned/timeout valid. stall=0; upstream advances this cycle. Next state IDLE.
- Latency: accept cycle N, request visible N+1. Response at cycle M≥N+1 gives out_valid at M+1. Zero-wait memory (resp at N+1) gives 3-cycle access.
- Store mask:
  - sb: 4'b0001<<addr[1:0]
  - sh: 4'b0011<<{addr[1],1'b0}
  - sw: 4'b1111
  - dmem_wdata = in_wdata<<(8*addr[1:0]).
- Loads: dmem_mbe=4'b1111.
  - lb/lbu: byte addr[1:0], sign-/zero-extended.
  - lh/lhu: half addr[1], sign-/zero-extended.
  - lw: full word.
- dmem_resp in IDLE or DONE is ignored.
- rst mid-BUSY: IDLE on the next edge; request dropped; no out_valid.
- DONE is always followed by IDLE, so back-to-back mem ops have ≥1 idle cycle between requests.

Optional Feature:
- MEM_ACCESS_TIMEOUT_EN defined:
  - Counter clears on BUSY entry and increments each BUSY cycle without dmem_resp.
  - On reaching TIMEOUT_CYCLES: drop request, go to DONE with timeout=1, load_data=0.
  - A dmem_resp in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; BUSY waits indefinitely; timeout tied 0.

Test Plan:
- lw addr=0x1000_0004, resp 2 cycles after request with rdata=0xDEAD_BEEF -> dmem_read held 2 cycles at 0x1000_0004, mbe=1111, out_valid with load_data=0xDEAD_BEEF, stall low in DONE cycle.
- lb/lbu addr=0x...03, rdata=0x80FF_FF7F -> lb load_data=0xFFFF_FF80, lbu 0x0000_0080; lh addr=0x...02 gives 0xFFFF_80FF.
- sb addr=0x...02, wdata=0x0000_00AB -> dmem_write=1, address 0x...00, mbe=0100, wdata=0x00AB_0000; sh addr=0x...02, wdata=0x1234 -> mbe=1100, wdata=0x1234_0000.
- lw addr=0x...02 -> no dmem_read ever, out_valid with misaligned=1 one cycle after accept; sh addr=0x...01 -> same.
- rst asserted while BUSY, then late dmem_resp -> dmem_read drops next edge, no out_valid, resp ignored, stall=0.
- MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no resp -> request high 4 cycles, out_valid with timeout=1, load_data=0.
